// File: rtl/counter_pkg.sv
// counter_pkg: shared sizing helper so common blocks size their counter buses identically
package counter_pkg;

    // Ceiling log2 of v, never less than 1 (a bus needs at least one bit)
    function automatic int clog2_min1(input longint unsigned v);
        int w;
        w = 0;
        for (longint unsigned p = 64'd1; p < v; p = p << 1) w++;
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/counter.sv
// counter: free-running modulo counter cycling 0..NUM, controlled only by reset
module counter
    import counter_pkg::*;
#(
    parameter int NUM   = 1,
    parameter int CNT_W = clog2_min1(longint'(NUM) + 64'd1)
) (
    input  logic             clk_sig,
    input  logic             reset_sig,
    output logic [CNT_W-1:0] counter_sig,
    output logic             tc_sig
);

    localparam logic [CNT_W-1:0] NUM_V = CNT_W'(NUM);

    if (NUM < 0) begin : g_num_chk
        $error("counter: NUM must be non-negative");
    end

    if (CNT_W < clog2_min1(longint'(NUM) + 64'd1)) begin : g_width_chk
        $error("counter: CNT_W too narrow to hold NUM");
    end

    logic [CNT_W-1:0] cnt_q = '0;
    logic [CNT_W-1:0] cnt_d;

    // Wrap on anything at or above NUM so an out-of-range value recovers in one edge
    always_comb cnt_d = (cnt_q >= NUM_V) ? '0 : cnt_q + CNT_W'(1);

    // Register with synchronous reset taking priority over wrap and increment
    always_ff @(posedge clk_sig) cnt_q <= reset_sig ? '0 : cnt_d;

    assign counter_sig = cnt_q;
    assign tc_sig      = (cnt_q == NUM_V);

endmodule

// File: tb/tb_counter.sv
// tb_counter: scoreboard bench over several counter parameterisations sharing one clock and reset
module tb_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [0:0] c1, c0;
    logic [2:0] c4, c5;
    logic [7:0] c3;
    logic       t1, t4, t5, t0, t3;

    always #5 clk = ~clk;

    counter #(.NUM(1), .CNT_W(1)) dut1 (.clk_sig(clk), .reset_sig(rst), .counter_sig(c1), .tc_sig(t1));
    counter #(.NUM(4))            dut4 (.clk_sig(clk), .reset_sig(rst), .counter_sig(c4), .tc_sig(t4));
    counter #(.NUM(5), .CNT_W(3)) dut5 (.clk_sig(clk), .reset_sig(rst), .counter_sig(c5), .tc_sig(t5));
    counter #(.NUM(0))            dut0 (.clk_sig(clk), .reset_sig(rst), .counter_sig(c0), .tc_sig(t0));
    counter #(.NUM(3), .CNT_W(8)) dut3 (.clk_sig(clk), .reset_sig(rst), .counter_sig(c3), .tc_sig(t3));

    typedef struct packed {
        logic [4:0][7:0] c;
        logic [4:0]      t;
    } exp_t;

    localparam int NUMS [5] = '{1, 4, 5, 0, 3};
    localparam int SEQ4 [6] = '{1, 2, 3, 4, 0, 1};

    int   checks = 0;
    int   errors = 0;
    int   m [5]  = '{0, 0, 0, 0, 0};
    int   bad5   = 0;
    int   badhi  = 0;
    exp_t sb [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic exp_t observe();
        exp_t o;
        o.c[0] = {7'b0, c1};
        o.c[1] = {5'b0, c4};
        o.c[2] = {5'b0, c5};
        o.c[3] = {7'b0, c0};
        o.c[4] = c3;
        o.t    = {t3, t0, t5, t4, t1};
        return o;
    endfunction

    task automatic step(input logic r);
        exp_t e, o;
        @(negedge clk);
        rst = r;
        for (int i = 0; i < 5; i++) begin
            m[i]   = r ? 0 : (m[i] >= NUMS[i] ? 0 : m[i] + 1);
            e.c[i] = 8'(m[i]);
            e.t[i] = (m[i] == NUMS[i]);
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        o = observe();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("n%0d_cnt", NUMS[i]), o.c[i], e.c[i]);
            chk($sformatf("n%0d_tc", NUMS[i]), o.t[i], e.t[i]);
        end
        if (c5 > 3'd5) bad5++;
        if (c3[7:2] != 6'd0) badhi++;
    endtask

    initial begin
        int last;
        exp_t o;
        #1;
        o = observe();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("pwr_n%0d_cnt", NUMS[i]), o.c[i], 0);
            chk($sformatf("pwr_n%0d_tc", NUMS[i]), o.t[i], NUMS[i] == 0);
        end
        repeat (3) step(1'b1);
        chk("rst_n1", c1, 0);
        chk("rst_n0_tc", t0, 1);
        chk("rst_n4_tc", t4, 0);
        last = -1;
        for (int i = 0; i < 100; i++) begin
            step(1'b0);
            if (i < 6) chk("n4_seq", c4, SEQ4[i]);
            if (i < 6) chk("n1_seq", c1, (i % 2) == 0);
            if (i < 6) chk("n1_tcseq", t1, (i % 2) == 0);
            if (t4) begin
                if (last >= 0) chk("n4_period", i - last, 5);
                last = i;
            end
        end
        chk("n5_range", bad5, 0);
        for (int k = 0; k < 10 && c4 != 3'd2; k++) step(1'b0);
        chk("n4_at2", c4, 2);
        step(1'b1);
        chk("mid_rst_n4", c4, 0);
        step(1'b1);
        chk("hold_rst_n4", c4, 0);
        chk("hold_rst_n0_tc", t0, 1);
        step(1'b0);
        chk("rel_n4_1", c4, 1);
        step(1'b0);
        chk("rel_n4_2", c4, 2);
        repeat (6) step(1'b0);
        force dut3.cnt_q = 8'd200;
        #1;
        chk("force_n3_cnt", c3, 200);
        chk("force_n3_tc", t3, 0);
        release dut3.cnt_q;
        m[4] = 200;
        step(1'b0);
        chk("recover_n3", c3, 0);
        step(1'b0);
        chk("recover_n3_next", c3, 1);
        chk("n3_hibits", badhi, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
